condicionador_sensores: RTL and testbench

//  Upstream conditioning stage for the irrigation controller. Synchronises and debounces the raw

---
 rtl/condicionador_sensores_if.sv | 29 ++
 rtl/condicionador_sensores.sv | 114 +++++++++++
 tb/tb_condicionador_sensores.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/condicionador_sensores_if.sv
// rtl/condicionador_sensores_if.sv - raw sensor pins in, conditioned sensor bits out
// master drives the raw field pins; slave is the conditioning stage.
interface condicionador_sensores_if;
  logic H_raw;
  logic M_raw;
  logic L_raw;
  logic Ua_raw;
  logic Us_raw;
  logic T_raw;
  logic H;
  logic M;
  logic L;
  logic Ua;
  logic Us;
  logic T;
  logic V;
  logic erro_sens;
  logic atualizado;

  modport master (
    output H_raw, M_raw, L_raw, Ua_raw, Us_raw, T_raw,
    input  H, M, L, Ua, Us, T, V, erro_sens, atualizado
  );

  modport slave (
    input  H_raw, M_raw, L_raw, Ua_raw, Us_raw, T_raw,
    output H, M, L, Ua, Us, T, V, erro_sens, atualizado
  );
endinterface

// File: rtl/condicionador_sensores.sv
// rtl/condicionador_sensores.sv - sensor sync/debounce and tank-level plausibility stage
// Define SENSOR_FAULT_LATCH_EN to make erro_sens sticky until reiniciar.
module condicionador_sensores #(
  parameter int DEB_CYCLES   = 50000,
  parameter int CNT_W        = 16,
  parameter int FAULT_CYCLES = 8
) (
  input logic clk,
  input logic reiniciar,
  condicionador_sensores_if.slave sens
);
  localparam int N_LANES = 6;
  localparam int FCNT_W  = $clog2(FAULT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FAULT_SAT = FCNT_W'(FAULT_CYCLES);

  // Lane order: {H, M, L, Ua, Us, T}
  logic [N_LANES-1:0] raw;
  logic [N_LANES-1:0] sync1_q;
  logic [N_LANES-1:0] sync2_q;
  logic [N_LANES-1:0] deb_q;
  logic [N_LANES-1:0] deb_d;
  logic [N_LANES-1:0] prev_q;
  logic [CNT_W-1:0]   cnt_q [N_LANES];
  logic [CNT_W-1:0]   cnt_d [N_LANES];
  logic [FCNT_W-1:0]  fcnt_q;
  logic [FCNT_W-1:0]  fcnt_d;
  logic               erro_q;
  logic               erro_d;
  logic               v_q;
  logic               v_d;
  logic               atual_q;
  logic               atual_d;
  logic               level_valid;

  assign raw = {sens.H_raw, sens.M_raw, sens.L_raw, sens.Ua_raw, sens.Us_raw, sens.T_raw};

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < N_LANES; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Float switches fill bottom-up, so only thermometer-coded levels are plausible.
  always_comb begin
    level_valid = 1'b0;
    case (deb_q[5:3])
      3'b000, 3'b001, 3'b011, 3'b111: level_valid = 1'b1;
      default:                        level_valid = 1'b0;
    endcase
  end

  always_comb begin
    fcnt_d = '0;
    if (!level_valid) begin
      fcnt_d = (fcnt_q == FAULT_SAT) ? fcnt_q : fcnt_q + 1'b1;
    end
    erro_d = (fcnt_d == FAULT_SAT);
`ifdef SENSOR_FAULT_LATCH_EN
    if (erro_q) begin
      fcnt_d = fcnt_q;
      erro_d = 1'b1;
    end
`endif
    v_d     = (deb_d[5:3] == 3'b000) && !erro_d;
    atual_d = |(deb_q ^ prev_q);
  end

  always_ff @(posedge clk or negedge reiniciar) begin
    if (!reiniciar) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      prev_q  <= '0;
      for (int i = 0; i < N_LANES; i++) begin
        cnt_q[i] <= '0;
      end
      fcnt_q  <= '0;
      erro_q  <= 1'b0;
      v_q     <= 1'b0;
      atual_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      prev_q  <= deb_q;
      for (int i = 0; i < N_LANES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      fcnt_q  <= fcnt_d;
      erro_q  <= erro_d;
      v_q     <= v_d;
      atual_q <= atual_d;
    end
  end

  assign sens.H          = deb_q[5];
  assign sens.M          = deb_q[4];
  assign sens.L          = deb_q[3];
  assign sens.Ua         = deb_q[2];
  assign sens.Us         = deb_q[1];
  assign sens.T          = deb_q[0];
  assign sens.V          = v_q;
  assign sens.erro_sens  = erro_q;
  assign sens.atualizado = atual_q;
endmodule

// File: tb/tb_condicionador_sensores.sv
// tb/tb_condicionador_sensores.sv - self-checking bench for condicionador_sensores
// Build with SENSOR_FAULT_LATCH_EN to exercise the sticky-fault variant.
module tb_condicionador_sensores;
  localparam int DEB = 4;
  localparam int FLT = 3;

  typedef struct {
    logic [5:0] raw;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] exp;
    int         at;
  } sb_t;

  logic clk = 1'b0;
  logic reiniciar;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic sb_en = 1'b0;
  sb_t  sb_q[$];
  vec_t vecs[7];
  logic [8:0] obs;

  condicionador_sensores_if sif ();

  condicionador_sensores #(
    .DEB_CYCLES(DEB),
    .CNT_W(16),
    .FAULT_CYCLES(FLT)
  ) dut (
    .clk(clk),
    .reiniciar(reiniciar),
    .sens(sif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign obs = {sif.H, sif.M, sif.L, sif.Ua, sif.Us, sif.T, sif.V, sif.erro_sens, sif.atualizado};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_raw(input logic [5:0] r);
    sif.H_raw  = r[5];
    sif.M_raw  = r[4];
    sif.L_raw  = r[3];
    sif.Ua_raw = r[2];
    sif.Us_raw = r[1];
    sif.T_raw  = r[0];
  endtask

  task automatic do_reset();
    set_raw(6'b000000);
    reiniciar = 1'b0;
    tick(2);
    reiniciar = 1'b1;
    tick(2);
  endtask

  // Scoreboard consumer: every atualizado pulse must match the oldest expectation.
  initial begin
    sb_t item;
    forever begin
      @(posedge clk);
      #1;
      if (sb_en && sif.atualizado) begin
        if (sb_q.size() == 0) begin
          chk("spurious_atualizado", {31'd0, sif.atualizado}, 32'd0);
        end else begin
          item = sb_q.pop_front();
          chk("sb_outputs", {24'd0, obs[8:1]}, {24'd0, item.exp});
          chk("sb_latency", cyc, item.at);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pulses;
    int w;
    sb_t item;

    vecs[0] = '{6'b001101, 8'b001101_0_0};
    vecs[1] = '{6'b011010, 8'b011010_0_0};
    vecs[2] = '{6'b111111, 8'b111111_0_0};
    vecs[3] = '{6'b000000, 8'b000000_1_0};
    vecs[4] = '{6'b000111, 8'b000111_1_0};
    vecs[5] = '{6'b001000, 8'b001000_0_0};
    vecs[6] = '{6'b000010, 8'b000010_1_0};

    set_raw(6'b000000);
    reiniciar = 1'b0;
    tick(3);
    chk("reset_outputs", {23'd0, obs}, 32'd0);
    reiniciar = 1'b1;
    tick(1);
    chk("release_V", {31'd0, sif.V}, 32'd1);
    chk("release_atualizado", {31'd0, sif.atualizado}, 32'd0);

    // Single lane latency: L rises at edge 2+DEB, pulse one edge later.
    sif.L_raw = 1'b1;
    tick(DEB + 1);
    chk("L_before_edge6", {31'd0, sif.L}, 32'd0);
    tick(1);
    chk("L_at_edge6", {31'd0, sif.L}, 32'd1);
    chk("V_at_edge6", {31'd0, sif.V}, 32'd0);
    chk("atual_edge6", {31'd0, sif.atualizado}, 32'd0);
    tick(1);
    chk("atual_edge7", {31'd0, sif.atualizado}, 32'd1);
    tick(1);
    chk("atual_edge8", {31'd0, sif.atualizado}, 32'd0);

    // A bounce one clock short of DEB must be filtered and reset the count.
    sif.Us_raw = 1'b1;
    tick(DEB - 1);
    sif.Us_raw = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (sif.atualizado) pulses++;
    end
    chk("bounce_Us", {31'd0, sif.Us}, 32'd0);
    chk("bounce_pulses", pulses, 0);
    sif.Us_raw = 1'b1;
    tick(DEB + 1);
    chk("restart_Us_edge5", {31'd0, sif.Us}, 32'd0);
    tick(1);
    chk("restart_Us_edge6", {31'd0, sif.Us}, 32'd1);
    tick(4);

    do_reset();
    sb_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_raw(vecs[i].raw);
      item.exp = vecs[i].exp;
      item.at  = cyc + DEB + 3;
      sb_q.push_back(item);
      w = 0;
      while (sb_q.size() != 0 && w < 20) begin
        tick(1);
        w++;
      end
      chk("sb_pending", sb_q.size(), 0);
      sb_q.delete();
      tick(2);
    end
    sb_en = 1'b0;

    // Implausible level 101: fault after FLT clocks of the debounced pattern.
    do_reset();
    set_raw(6'b101000);
    tick(DEB + 2);
    chk("fault_hml", {29'd0, sif.H, sif.M, sif.L}, 32'd5);
    chk("fault_erro_edge6", {31'd0, sif.erro_sens}, 32'd0);
    tick(FLT - 1);
    chk("fault_erro_early", {31'd0, sif.erro_sens}, 32'd0);
    tick(1);
    chk("fault_erro_set", {31'd0, sif.erro_sens}, 32'd1);
    chk("fault_V", {31'd0, sif.V}, 32'd0);
    tick(5);
    chk("fault_erro_sat", {31'd0, sif.erro_sens}, 32'd1);
    sif.M_raw = 1'b1;
    tick(DEB + 2);
    chk("fix_hml", {29'd0, sif.H, sif.M, sif.L}, 32'd7);
    chk("fix_erro_edge6", {31'd0, sif.erro_sens}, 32'd1);
    tick(1);
`ifdef SENSOR_FAULT_LATCH_EN
    chk("latch_erro_held", {31'd0, sif.erro_sens}, 32'd1);
    set_raw(6'b000000);
    tick(10);
    chk("latch_hml_empty", {29'd0, sif.H, sif.M, sif.L}, 32'd0);
    chk("latch_erro_empty", {31'd0, sif.erro_sens}, 32'd1);
    chk("latch_V_held0", {31'd0, sif.V}, 32'd0);
    reiniciar = 1'b0;
    #1;
    chk("latch_erro_reset", {31'd0, sif.erro_sens}, 32'd0);
    tick(1);
    reiniciar = 1'b1;
    tick(1);
    chk("latch_V_after_reset", {31'd0, sif.V}, 32'd1);
`else
    chk("fix_erro_clear", {31'd0, sif.erro_sens}, 32'd0);
    chk("fix_V", {31'd0, sif.V}, 32'd0);
    set_raw(6'b000000);
    tick(DEB + 2);
    chk("empty_V", {31'd0, sif.V}, 32'd1);
    chk("empty_erro", {31'd0, sif.erro_sens}, 32'd0);
`endif

    // Asynchronous reset mid-count, then the full latency again.
    do_reset();
    sif.Ua_raw = 1'b1;
    tick(DEB + 2);
    chk("mid_Ua_set", {31'd0, sif.Ua}, 32'd1);
    tick(2);
    sif.T_raw = 1'b1;
    tick(4);
    reiniciar = 1'b0;
    #1;
    chk("async_reset_outputs", {23'd0, obs}, 32'd0);
    #1;
    reiniciar = 1'b1;
    tick(DEB + 1);
    chk("rerun_edge5", {30'd0, sif.Ua, sif.T}, 32'd0);
    tick(1);
    chk("rerun_edge6", {30'd0, sif.Ua, sif.T}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
